// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use interlock and redirect squash.
// Optional bubble/redirect performance counters under IDEX_PERF_CNT_EN.
module idex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            validD_i,
    input  logic [XLEN-1:0] pcD_i,
    input  logic [XLEN-1:0] rd1D_i,
    input  logic [XLEN-1:0] rd2D_i,
    input  logic [XLEN-1:0] immD_i,
    input  logic [4:0]      rs1D_i,
    input  logic [4:0]      rs2D_i,
    input  logic [4:0]      rdD_i,
    input  logic            usesrs1D_i,
    input  logic            usesrs2D_i,
    input  logic            writesregD_i,
    input  logic            memreadD_i,
    input  logic            memwriteD_i,
    input  logic            alusrcD_i,
    input  logic            branchD_i,
    input  logic            jumpD_i,
    input  logic [3:0]      aluopD_i,
    input  logic            redirectE_i,
    output logic            validE_o,
    output logic [XLEN-1:0] pcE_o,
    output logic [XLEN-1:0] rd1E_o,
    output logic [XLEN-1:0] rd2E_o,
    output logic [XLEN-1:0] immE_o,
    output logic [4:0]      rs1E_o,
    output logic [4:0]      rs2E_o,
    output logic [4:0]      rdE_o,
    output logic            writesregE_o,
    output logic            memreadE_o,
    output logic            memwriteE_o,
    output logic            alusrcE_o,
    output logic            branchE_o,
    output logic            jumpE_o,
    output logic [3:0]      aluopE_o,
`ifdef IDEX_PERF_CNT_EN
    output logic [31:0]     bubblecnt_o,
    output logic [31:0]     redirectcnt_o,
`endif
    output logic            stallF_o,
    output logic            stallD_o,
    output logic            flushD_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            writesreg_q, writesreg_d, memread_q, memread_d;
    logic            memwrite_q, memwrite_d, alusrc_q, alusrc_d;
    logic            branch_q, branch_d, jump_q, jump_d;
    logic [3:0]      aluop_q, aluop_d;
    logic            luh;
    logic            bubble;

    always_comb begin
        luh = valid_q && memread_q && writesreg_q && (rd_q != 5'd0) && validD_i &&
              ((usesrs1D_i && (rs1D_i == rd_q)) || (usesrs2D_i && (rs2D_i == rd_q)));
    end

    assign stallF_o = luh & ~redirectE_i;
    assign stallD_o = luh & ~redirectE_i;
    assign flushD_o = redirectE_i;
    assign bubble   = redirectE_i | luh;

    always_comb begin
        valid_d     = validD_i;
        pc_d        = pcD_i;
        rd1_d       = rd1D_i;
        rd2_d       = rd2D_i;
        imm_d       = immD_i;
        rs1_d       = rs1D_i;
        rs2_d       = rs2D_i;
        rd_d        = rdD_i;
        writesreg_d = writesregD_i;
        memread_d   = memreadD_i;
        memwrite_d  = memwriteD_i;
        alusrc_d    = alusrcD_i;
        branch_d    = branchD_i;
        jump_d      = jumpD_i;
        aluop_d     = aluopD_i;
        if (bubble) begin
            // Data fields hold; only identity and side-effect bits are cleared.
            valid_d     = 1'b0;
            writesreg_d = 1'b0;
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
            rd_d        = 5'd0;
            rs1_d       = 5'd0;
            rs2_d       = 5'd0;
            pc_d        = pc_q;
            rd1_d       = rd1_q;
            rd2_d       = rd2_q;
            imm_d       = imm_q;
            aluop_d     = aluop_q;
            alusrc_d    = alusrc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            writesreg_q <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            aluop_q     <= 4'd0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            writesreg_q <= writesreg_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            alusrc_q    <= alusrc_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            aluop_q     <= aluop_d;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubblecnt_q, bubblecnt_d, redirectcnt_q, redirectcnt_d;

    // A simultaneous redirect and load-use counts only as a redirect.
    always_comb begin
        bubblecnt_d   = bubblecnt_q;
        redirectcnt_d = redirectcnt_q;
        if (redirectE_i) begin
            redirectcnt_d = redirectcnt_q + 32'd1;
        end else if (luh) begin
            bubblecnt_d = bubblecnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubblecnt_q   <= 32'd0;
            redirectcnt_q <= 32'd0;
        end else begin
            bubblecnt_q   <= bubblecnt_d;
            redirectcnt_q <= redirectcnt_d;
        end
    end

    assign bubblecnt_o   = bubblecnt_q;
    assign redirectcnt_o = redirectcnt_q;
`endif

    assign validE_o     = valid_q;
    assign pcE_o        = pc_q;
    assign rd1E_o       = rd1_q;
    assign rd2E_o       = rd2_q;
    assign immE_o       = imm_q;
    assign rs1E_o       = rs1_q;
    assign rs2E_o       = rs2_q;
    assign rdE_o        = rd_q;
    assign writesregE_o = writesreg_q;
    assign memreadE_o   = memread_q;
    assign memwriteE_o  = memwrite_q;
    assign alusrcE_o    = alusrc_q;
    assign branchE_o    = branch_q;
    assign jumpE_o      = jump_q;
    assign aluopE_o     = aluop_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: capture, load-use stall, redirect priority, async reset.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validD, usesrs1D, usesrs2D, writesregD, memreadD, memwriteD;
    logic        alusrcD, branchD, jumpD, redirectE;
    logic [31:0] pcD, rd1D, rd2D, immD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [3:0]  aluopD;
    logic        validE, writesregE, memreadE, memwriteE, alusrcE, branchE, jumpE;
    logic [31:0] pcE, rd1E, rd2E, immE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [3:0]  aluopE;
    logic        stallF, stallD, flushD;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubblecnt, redirectcnt;
    logic [31:0] bc_save, rc_save;
`endif

    int unsigned n_total = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    idex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .validD_i(validD), .pcD_i(pcD), .rd1D_i(rd1D), .rd2D_i(rd2D), .immD_i(immD),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rdD_i(rdD),
        .usesrs1D_i(usesrs1D), .usesrs2D_i(usesrs2D),
        .writesregD_i(writesregD), .memreadD_i(memreadD), .memwriteD_i(memwriteD),
        .alusrcD_i(alusrcD), .branchD_i(branchD), .jumpD_i(jumpD), .aluopD_i(aluopD),
        .redirectE_i(redirectE),
        .validE_o(validE), .pcE_o(pcE), .rd1E_o(rd1E), .rd2E_o(rd2E), .immE_o(immE),
        .rs1E_o(rs1E), .rs2E_o(rs2E), .rdE_o(rdE),
        .writesregE_o(writesregE), .memreadE_o(memreadE), .memwriteE_o(memwriteE),
        .alusrcE_o(alusrcE), .branchE_o(branchE), .jumpE_o(jumpE), .aluopE_o(aluopE),
`ifdef IDEX_PERF_CNT_EN
        .bubblecnt_o(bubblecnt), .redirectcnt_o(redirectcnt),
`endif
        .stallF_o(stallF), .stallD_o(stallD), .flushD_o(flushD)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_d();
        validD = 0; usesrs1D = 0; usesrs2D = 0; writesregD = 0; memreadD = 0;
        memwriteD = 0; alusrcD = 0; branchD = 0; jumpD = 0; redirectE = 0;
        pcD = 0; rd1D = 0; rd2D = 0; immD = 0; rs1D = 0; rs2D = 0; rdD = 0; aluopD = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present "lw x7" in decode, then clock it into execute.
    task automatic load_x7_to_e(input logic [31:0] pc);
        clr_d();
        validD = 1; memreadD = 1; writesregD = 1; rdD = 5'd7; rs1D = 5'd2;
        usesrs1D = 1; pcD = pc; alusrcD = 1;
        tick();
    endtask

    initial begin
        clr_d();
        rst_n = 0;
        #3;
        chk("reset_validE", validE, 0);
        chk("reset_pcE", pcE, 0);
        chk("reset_rd1E", rd1E, 0);
        chk("reset_stallF", stallF, 0);
        chk("reset_flushD", flushD, 0);
        #4 rst_n = 1;
        tick();

        // Plain capture.
        clr_d();
        validD = 1; rdD = 5'd5; rd1D = 32'h1234; aluopD = 4'd3; pcD = 32'h100;
        writesregD = 1; rs1D = 5'd9; usesrs1D = 1;
        tick();
        chk("cap_rdE", rdE, 5);
        chk("cap_rd1E", rd1E, 32'h1234);
        chk("cap_aluopE", aluopE, 3);
        chk("cap_validE", validE, 1);
        chk("cap_pcE", pcE, 32'h100);
        chk("cap_stallF", stallF, 0);

        // Load-use: lw x7 then add x8,x7,x1.
        load_x7_to_e(32'h104);
        chk("lu_memreadE", memreadE, 1);
        clr_d();
        validD = 1; rdD = 5'd8; rs1D = 5'd7; rs2D = 5'd1; usesrs1D = 1; usesrs2D = 1;
        writesregD = 1; pcD = 32'h108; rd1D = 32'hAAAA;
        #1;
        chk("lu_stallF", stallF, 1);
        chk("lu_stallD", stallD, 1);
        chk("lu_flushD", flushD, 0);
        tick();
        chk("lu_bub_rdE", rdE, 0);
        chk("lu_bub_memreadE", memreadE, 0);
        chk("lu_bub_validE", validE, 0);
        chk("lu_bub_pcE_held", pcE, 32'h104);
        chk("lu_bub_alusrcE_held", alusrcE, 1);
        chk("lu_stall_released", stallF, 0);
        tick();
        chk("lu_add_rs1E", rs1E, 7);
        chk("lu_add_rdE", rdE, 8);
        chk("lu_add_validE", validE, 1);
        chk("lu_add_rd1E", rd1E, 32'hAAAA);

        // Load to x0 never stalls; rd=0 with writesreg passes through.
        clr_d();
        validD = 1; memreadD = 1; writesregD = 1; rdD = 5'd0; rs1D = 5'd3; usesrs1D = 1;
        tick();
        chk("x0_rdE", rdE, 0);
        chk("x0_writesregE", writesregE, 1);
        clr_d();
        validD = 1; rs1D = 5'd0; usesrs1D = 1; rdD = 5'd4; writesregD = 1;
        #1;
        chk("x0_no_stall", stallF, 0);

        // rs2 match but not used.
        load_x7_to_e(32'h200);
        clr_d();
        validD = 1; rs1D = 5'd4; usesrs1D = 1; rs2D = 5'd7; usesrs2D = 0; rdD = 5'd9;
        #1;
        chk("itype_no_stall", stallD, 0);

        // rs2 used and matching does stall.
        usesrs2D = 1;
        #1;
        chk("rs2_stall", stallD, 1);

        // validD=0 suppresses the hazard; captured as-is with control bits kept.
        validD = 0; memwriteD = 1;
        #1;
        chk("invalid_no_stall", stallF, 0);
        tick();
        chk("invalid_validE", validE, 0);
        chk("invalid_memwriteE", memwriteE, 1);

        // Redirect beats load-use.
        load_x7_to_e(32'h300);
`ifdef IDEX_PERF_CNT_EN
        bc_save = bubblecnt; rc_save = redirectcnt;
`endif
        clr_d();
        validD = 1; rs1D = 5'd7; usesrs1D = 1; rdD = 5'd10; writesregD = 1;
        redirectE = 1; branchD = 1; jumpD = 1;
        #1;
        chk("redir_stallF", stallF, 0);
        chk("redir_flushD", flushD, 1);
        tick();
        redirectE = 0;
        chk("redir_bub_validE", validE, 0);
        chk("redir_bub_rdE", rdE, 0);
        chk("redir_bub_branchE", branchE, 0);
        chk("redir_bub_jumpE", jumpE, 0);
`ifdef IDEX_PERF_CNT_EN
        chk("redir_cnt_inc", redirectcnt, rc_save + 32'd1);
        chk("redir_bubcnt_same", bubblecnt, bc_save);
`endif

        // Async reset mid-stall.
        load_x7_to_e(32'h400);
        clr_d();
        validD = 1; rs1D = 5'd7; usesrs1D = 1; rdD = 5'd11; writesregD = 1;
        #1;
        chk("rst_pre_stall", stallF, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_validE", validE, 0);
        chk("rst_mid_pcE", pcE, 0);
        chk("rst_mid_rdE", rdE, 0);
        chk("rst_mid_memreadE", memreadE, 0);
        chk("rst_mid_stallF", stallF, 0);
        #10 rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
